// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage for the single-cycle RISC-V core. Holds the program
// counter, issues word reads to instruction memory over a request/acknowledge
// handshake, presents each fetched instruction with its PC to the decoder and
// datapath, and computes the next PC from the redirects fed back by execute.
//
// Optional feature macro: INST_FETCH_MISALIGN_TRAP_EN
//   defined   : a next PC with bits [1:0] != 0 parks the FSM in S_TRAP with
//               misalign=1 until reset; pc holds the faulting target.
//   undefined : next PC bits [1:0] are forced to 2'b00; misalign is tied 0.
//
// Parameters:
//   RESET_PC     PC loaded on reset (word-aligned)
//   NOP_INST     value driven on inst whenever inst_valid is 0
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   stall          in   1   downstream not ready; hold current instruction
//   jal            in   1   redirect to br_jal_target
//   jalr           in   1   redirect to jalr_target with bit 0 cleared
//   branch_taken   in   1   redirect to br_jal_target
//   br_jal_target  in  32   PC + immediate from execute
//   jalr_target    in  32   rs1 + immediate from execute
//   i_mem_req      out  1   read request to instruction memory
//   i_mem_addr     out 32   read address (always equals pc)
//   i_mem_rdata    in  32   read data, valid with i_mem_ack
//   i_mem_ack      in   1   read complete
//   inst           out 32   instruction to decoder (NOP_INST when not valid)
//   pc             out 32   PC of inst
//   inst_valid     out  1   inst/pc hold a fetched instruction
//   misalign       out  1   misaligned-target trap flag
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jal,
    input  logic        jalr,
    input  logic        branch_taken,
    input  logic [31:0] br_jal_target,
    input  logic [31:0] jalr_target,
    output logic        i_mem_req,
    output logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic        misalign
);

    // Memory handshake: i_mem_req is held high with i_mem_addr stable for as
    // long as the FSM sits in S_REQ. A transfer completes on the clock edge
    // where i_mem_req and i_mem_ack are both 1; i_mem_rdata is captured on
    // that edge. i_mem_ack seen while i_mem_req is 0 is ignored. Downstream,
    // inst_valid acts as valid and !stall as ready: the instruction is
    // consumed on the edge where inst_valid=1 and stall=0.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        target_misaligned;

    // Redirect priority: jalr > jal > branch_taken > sequential.
    always_comb begin
        target = pc_q + 32'd4;
        if (jalr) begin
            target = {jalr_target[31:1], 1'b0};
        end else if (jal) begin
            target = br_jal_target;
        end else if (branch_taken) begin
            target = br_jal_target;
        end
    end

`ifdef INST_FETCH_MISALIGN_TRAP_EN
    assign next_pc           = target;
    assign target_misaligned = |target[1:0];
`else
    // Without the trap the low bits are simply dropped so fetch stays aligned.
    logic [1:0] unused_target_bits;
    assign unused_target_bits = target[1:0];
    assign next_pc            = {target[31:2], 2'b00};
    assign target_misaligned  = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (i_mem_ack) state_nxt = S_VALID;
            S_VALID: begin
                if (!stall) begin
                    state_nxt = target_misaligned ? S_TRAP : S_REQ;
                end
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from registered state only) ----
    always_comb begin
        i_mem_req  = (state == S_REQ);
        inst_valid = (state == S_VALID);
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        misalign   = (state == S_TRAP);
`else
        misalign   = 1'b0;
`endif
    end

    // ---------------- PC and instruction registers ----------------
    // pc advances only when the current instruction is consumed; on a trap it
    // takes the faulting target so software can inspect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
        end else begin
            if (state == S_VALID && !stall) begin
                pc_q <= next_pc;
            end
            if (state == S_REQ && i_mem_ack) begin
                inst_q <= i_mem_rdata;
            end
        end
    end

    assign pc         = pc_q;
    assign i_mem_addr = pc_q;
    // Decoder never sees stale data between fetches.
    assign inst       = inst_valid ? inst_q : NOP_INST;

endmodule
